// File: rtl/move_sequencer_pkg.sv
// Shared game definitions: sequencer state encoding, default geometry and timing, and the
// coordinate clamp used when a move is committed.
package move_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHWait,
    StVWait,
    StCommit
  } seq_state_e;

  localparam int unsigned DefTickDiv = 500000;
  localparam int unsigned DefTimeout = 64;

  localparam int DefMarioWidth  = 42;
  localparam int DefMarioHeight = 42;
  localparam int DefScreenWidth = 640;
  localparam int DefScreenHeight = 480;
  localparam int DefStartX      = 40;
  localparam int DefStartY      = 398;

  // Signed clamp into [0, hi]; movers may return negative or off-screen coordinates.
  function automatic int clamp_coord(input int v, input int hi);
    int r;
    r = v;
    if (v < 0) begin
      r = 0;
    end else if (v > hi) begin
      r = hi;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: counts 0..TICK_DIV-1 and flags the final count as the movement tick.
module tick_divider #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CntMax);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Per-tick move sequencer: asks the horizontal mover, then the vertical mover, and commits the
// clamped result atomically. Stalled handshakes time out; ticks arriving while busy are counted.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV      = DefTickDiv,
  parameter int unsigned TIMEOUT       = DefTimeout,
  parameter int          MARIO_WIDTH   = DefMarioWidth,
  parameter int          MARIO_HEIGHT  = DefMarioHeight,
  parameter int          SCREEN_WIDTH  = DefScreenWidth,
  parameter int          SCREEN_HEIGHT = DefScreenHeight,
  parameter int          START_X       = DefStartX,
  parameter int          START_Y       = DefStartY
) (
  input  logic       vga_clock,
  input  logic       reset,
  input  logic       pause,
  output logic       h_req,
  input  logic       h_ack,
  input  int         h_x_in,
  output logic       v_req,
  input  logic       v_ack,
  input  int         v_y_in,
  output int         cur_x,
  output int         cur_y,
  output int         mario_x,
  output int         mario_y,
  output logic       frame_done,
  output logic       timeout_flag,
  output logic [7:0] overrun_count
);

  localparam int XMax = SCREEN_WIDTH - MARIO_WIDTH;
  localparam int YMax = SCREEN_HEIGHT - MARIO_HEIGHT;

  logic tick;

  seq_state_e  state_q, state_d;
  int          x_pending_q, x_pending_d;
  int          y_pending_q, y_pending_d;
  int          mario_x_q, mario_x_d;
  int          mario_y_q, mario_y_d;
  int unsigned wait_q, wait_d;
  logic        frame_done_q, frame_done_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  overrun_q, overrun_d;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clk_i (vga_clock),
    .rst_i (reset),
    .tick_o(tick)
  );

  always_comb begin
    state_d      = state_q;
    x_pending_d  = x_pending_q;
    y_pending_d  = y_pending_q;
    mario_x_d    = mario_x_q;
    mario_y_d    = mario_y_q;
    wait_d       = wait_q;
    frame_done_d = 1'b0;
    timeout_d    = timeout_q;
    overrun_d    = overrun_q;

    // A tick while busy is dropped, never queued.
    if (tick && (state_q != StIdle) && (overrun_q != 8'hff)) begin
      overrun_d = overrun_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        wait_d = '0;
        if (tick && !pause) begin
          state_d = StHWait;
        end
      end
      StHWait: begin
        if (h_ack) begin
          x_pending_d = h_x_in;
          wait_d      = '0;
          state_d     = StVWait;
        end else if (wait_q == TIMEOUT - 1) begin
          wait_d    = '0;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          wait_d = wait_q + 1;
        end
      end
      StVWait: begin
        // Ack is checked first so it wins over an expiry in the same cycle.
        if (v_ack) begin
          y_pending_d = v_y_in;
          wait_d      = '0;
          state_d     = StCommit;
        end else if (wait_q == TIMEOUT - 1) begin
          x_pending_d = mario_x_q;
          wait_d      = '0;
          timeout_d   = 1'b1;
          state_d     = StIdle;
        end else begin
          wait_d = wait_q + 1;
        end
      end
      StCommit: begin
        mario_x_d    = clamp_coord(x_pending_q, XMax);
        mario_y_d    = clamp_coord(y_pending_q, YMax);
        frame_done_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    h_req         = (state_q == StHWait);
    v_req         = (state_q == StVWait);
    cur_x         = ((state_q == StVWait) || (state_q == StCommit)) ? x_pending_q : mario_x_q;
    cur_y         = (state_q == StCommit) ? y_pending_q : mario_y_q;
    mario_x       = mario_x_q;
    mario_y       = mario_y_q;
    frame_done    = frame_done_q;
    timeout_flag  = timeout_q;
    overrun_count = overrun_q;
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state_q      <= StIdle;
      x_pending_q  <= START_X;
      y_pending_q  <= START_Y;
      mario_x_q    <= START_X;
      mario_y_q    <= START_Y;
      wait_q       <= '0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= '0;
    end else begin
      state_q      <= state_d;
      x_pending_q  <= x_pending_d;
      y_pending_q  <= y_pending_d;
      mario_x_q    <= mario_x_d;
      mario_y_q    <= mario_y_d;
      wait_q       <= wait_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed and randomized move sequences checked against a
// transaction-level model (tick schedule, handshake latencies, clamp, dropped-tick count).
module tb_move_sequencer;

  localparam int TD   = 4;
  localparam int XMAX = 640 - 42;
  localparam int YMAX = 480 - 42;

  logic       vga_clock = 1'b0;
  logic       reset     = 1'b1;

  logic       pause, h_ack, v_ack;
  int         h_x_in, v_y_in;
  logic       h_req, v_req, frame_done, timeout_flag;
  int         cur_x, cur_y, mario_x, mario_y;
  logic [7:0] overrun_count;

  logic       pause_b, h_ack_b, v_ack_b;
  int         h_x_in_b, v_y_in_b;
  logic       h_req_b, v_req_b, frame_done_b, timeout_flag_b;
  int         cur_x_b, cur_y_b, mario_x_b, mario_y_b;
  logic [7:0] overrun_count_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_mx   = 40;
  int exp_my   = 398;
  int exp_ovr  = 0;

  always #5 vga_clock = ~vga_clock;

  move_sequencer #(
    .TICK_DIV(TD),
    .TIMEOUT (64)
  ) dut_a (
    .vga_clock    (vga_clock),
    .reset        (reset),
    .pause        (pause),
    .h_req        (h_req),
    .h_ack        (h_ack),
    .h_x_in       (h_x_in),
    .v_req        (v_req),
    .v_ack        (v_ack),
    .v_y_in       (v_y_in),
    .cur_x        (cur_x),
    .cur_y        (cur_y),
    .mario_x      (mario_x),
    .mario_y      (mario_y),
    .frame_done   (frame_done),
    .timeout_flag (timeout_flag),
    .overrun_count(overrun_count)
  );

  move_sequencer #(
    .TICK_DIV(TD),
    .TIMEOUT (8)
  ) dut_b (
    .vga_clock    (vga_clock),
    .reset        (reset),
    .pause        (pause_b),
    .h_req        (h_req_b),
    .h_ack        (h_ack_b),
    .h_x_in       (h_x_in_b),
    .v_req        (v_req_b),
    .v_ack        (v_ack_b),
    .v_y_in       (v_y_in_b),
    .cur_x        (cur_x_b),
    .cur_y        (cur_y_b),
    .mario_x      (mario_x_b),
    .mario_y      (mario_y_b),
    .frame_done   (frame_done_b),
    .timeout_flag (timeout_flag_b),
    .overrun_count(overrun_count_b)
  );

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Number of tick cycles (cycle index k with k mod TD == TD-1) in [a, b].
  function automatic int ticks_in(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if ((k % TD) == TD - 1) n++;
    return n;
  endfunction

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge vga_clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    h_ack = 1'b0; v_ack = 1'b0; h_ack_b = 1'b0; v_ack_b = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    cyc = 0;
    exp_mx = 40; exp_my = 398; exp_ovr = 0;
  endtask

  // One full sequence on dut_a: h_ack after hd waiting cycles, v_ack after vd waiting cycles.
  task automatic run_txn(input int hd, input int vd, input int x, input int y, input bit pz,
                         input string tag, output int t_tick);
    int seen;
    int t;
    seen   = 0;
    t_tick = -1;
    pause  = 1'b0;
    for (int i = 0; i < 3 * TD && seen == 0; i++) begin
      if (h_req) begin
        seen = 1;
      end else begin
        h_ack = 1'($urandom_range(0, 1));
        v_ack = 1'($urandom_range(0, 1));
        step();
      end
    end
    h_ack = 1'b0;
    v_ack = 1'b0;
    check_eq({tag, " h_req rise"}, int'(h_req), 1);
    if (!h_req) return;
    t      = cyc - 1;
    t_tick = t;
    check_eq({tag, " tick phase"}, t % TD, TD - 1);
    check_eq({tag, " cur_x in h_wait"}, cur_x, exp_mx);
    pause  = pz;
    h_x_in = x;
    v_y_in = y;
    for (int i = 0; i < hd; i++) begin
      v_ack = 1'($urandom_range(0, 1));
      step();
    end
    check_eq({tag, " h_req held"}, int'(h_req), 1);
    h_ack = 1'b1;
    v_ack = 1'b0;
    step();
    h_ack = 1'b0;
    check_eq({tag, " h_req drop"}, int'(h_req), 0);
    check_eq({tag, " v_req up"}, int'(v_req), 1);
    check_eq({tag, " cur_x pending"}, cur_x, x);
    check_eq({tag, " overrun at v_wait"}, int'(overrun_count),
             sat8(exp_ovr + ticks_in(t + 1, t + hd + 1)));
    for (int i = 0; i < vd; i++) begin
      h_ack = 1'($urandom_range(0, 1));
      step();
    end
    h_ack = 1'b0;
    v_ack = 1'b1;
    step();
    v_ack = 1'b0;
    check_eq({tag, " no early frame_done"}, int'(frame_done), 0);
    check_eq({tag, " cur_y pending"}, cur_y, y);
    step();
    pause = 1'b1;
    check_eq({tag, " frame_done"}, int'(frame_done), 1);
    check_eq({tag, " latency"}, cyc - t, 1 + (hd + 1) + (vd + 1) + 1);
    check_eq({tag, " mario_x"}, mario_x, clamp(x, XMAX));
    check_eq({tag, " mario_y"}, mario_y, clamp(y, YMAX));
    exp_ovr = sat8(exp_ovr + ticks_in(t + 1, cyc - 1));
    check_eq({tag, " overrun"}, int'(overrun_count), exp_ovr);
    exp_mx = clamp(x, XMAX);
    exp_my = clamp(y, YMAX);
    step();
    check_eq({tag, " frame_done single"}, int'(frame_done), 0);
    check_eq({tag, " cur_x idle"}, cur_x, exp_mx);
  endtask

  // One sequence on dut_b (TIMEOUT=8); ack_at = v_req cycle index carrying v_ack, -1 for never.
  task automatic run_b(input int ack_at, input int x, input int y, input string tag,
                       output int n_vreq, output int n_fd);
    int seen;
    seen    = 0;
    n_vreq  = 0;
    n_fd    = 0;
    pause_b = 1'b0;
    for (int i = 0; i < 3 * TD && seen == 0; i++) begin
      if (h_req_b) seen = 1;
      else step();
    end
    pause_b = 1'b1;
    check_eq({tag, " h_req rise"}, int'(h_req_b), 1);
    if (!h_req_b) return;
    h_ack_b  = 1'b1;
    h_x_in_b = x;
    v_y_in_b = y;
    step();
    h_ack_b = 1'b0;
    while (v_req_b && n_vreq < 20) begin
      v_ack_b = (ack_at == n_vreq);
      step();
      v_ack_b = 1'b0;
      n_vreq++;
      if (frame_done_b) n_fd++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (frame_done_b) n_fd++;
    end
  endtask

  initial begin
    int t, nv, nf, hd, vd, x, y;
    bit pz;
    bit saw_req;

    pause   = 1'b0; h_ack   = 1'b0; v_ack   = 1'b0; h_x_in   = 0; v_y_in   = 0;
    pause_b = 1'b1; h_ack_b = 1'b0; v_ack_b = 1'b0; h_x_in_b = 0; v_y_in_b = 0;
    reset = 1'b1;
    repeat (2) @(posedge vga_clock);
    #1;
    reset = 1'b0;
    cyc = 0;

    check_eq("rst mario_x", mario_x, 40);
    check_eq("rst mario_y", mario_y, 398);
    check_eq("rst cur_x", cur_x, 40);
    check_eq("rst cur_y", cur_y, 398);
    check_eq("rst h_req", int'(h_req), 0);
    check_eq("rst v_req", int'(v_req), 0);
    check_eq("rst frame_done", int'(frame_done), 0);
    check_eq("rst timeout_flag", int'(timeout_flag), 0);
    check_eq("rst overrun", int'(overrun_count), 0);

    run_txn(0, 0, 100, 200, 1'b0, "basic", t);
    check_eq("basic first tick cycle", t, TD - 1);
    run_txn(0, 0, 630, -5, 1'b0, "clamp", t);

    do_reset();
    run_txn(10, 0, 300, 250, 1'b0, "overrun", t);

    // Paused across three ticks: no sequence starts and nothing is counted.
    pause   = 1'b1;
    saw_req = 1'b0;
    for (int i = 0; i < 3 * TD; i++) begin
      step();
      if (h_req) saw_req = 1'b1;
    end
    check_eq("pause h_req", int'(saw_req), 0);
    check_eq("pause overrun", int'(overrun_count), exp_ovr);

    for (int i = 0; i < 16; i++) begin
      hd = int'($urandom_range(0, 7));
      vd = int'($urandom_range(0, 7));
      x  = int'($urandom_range(0, 900)) - 100;
      y  = int'($urandom_range(0, 700)) - 100;
      pz = 1'($urandom_range(0, 1));
      run_txn(hd, vd, x, y, pz, $sformatf("rnd%0d", i), t);
    end

    // v_ack on the last allowed cycle beats the expiry.
    run_b(7, 222, 111, "ack_prio", nv, nf);
    check_eq("ack_prio v_req cycles", nv, 8);
    check_eq("ack_prio frame_done", nf, 1);
    check_eq("ack_prio mario_x", mario_x_b, 222);
    check_eq("ack_prio mario_y", mario_y_b, 111);
    check_eq("ack_prio timeout_flag", int'(timeout_flag_b), 0);

    run_b(-1, 333, 44, "timeout", nv, nf);
    check_eq("timeout v_req cycles", nv, 8);
    check_eq("timeout frame_done", nf, 0);
    check_eq("timeout flag", int'(timeout_flag_b), 1);
    check_eq("timeout mario_x", mario_x_b, 222);
    check_eq("timeout mario_y", mario_y_b, 111);
    repeat (6) step();
    check_eq("timeout flag sticky", int'(timeout_flag_b), 1);

    // Reset landing in V_WAIT abandons the move.
    pause = 1'b0;
    saw_req = 1'b0;
    for (int i = 0; i < 3 * TD && !saw_req; i++) begin
      if (h_req) saw_req = 1'b1;
      else step();
    end
    check_eq("vrst h_req rise", int'(h_req), 1);
    h_ack  = 1'b1;
    h_x_in = 123;
    step();
    h_ack = 1'b0;
    check_eq("vrst in v_wait", int'(v_req), 1);
    do_reset();
    check_eq("vrst v_req", int'(v_req), 0);
    check_eq("vrst h_req", int'(h_req), 0);
    check_eq("vrst mario_x", mario_x, 40);
    check_eq("vrst mario_y", mario_y, 398);
    check_eq("vrst cur_x", cur_x, 40);
    check_eq("vrst frame_done", int'(frame_done), 0);
    check_eq("vrst overrun", int'(overrun_count), 0);
    check_eq("vrst clears timeout", int'(timeout_flag_b), 0);

    run_txn(2, 3, 500, 400, 1'b0, "post_rst", t);
    check_eq("post_rst first tick cycle", t, TD - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
